fxu_res_station: RTL and testbench

FXU_RES_STATION -- requirements
Module: fxu_res_station

---
 rtl/ooo_pkg.sv | 33 +++
 rtl/rs_age_picker.sv | 21 ++
 rtl/fxu_res_station.sv | 175 +++++++++++++++++
 tb/tb_fxu_res_station.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: tag/data widths and the
// reservation-station entry record.
package ooo_pkg;

   localparam int TAG_W  = 4;
   localparam int DATA_W = 16;
   localparam int OPC_W  = 4;
   localparam int IMM_W  = 8;

   typedef struct packed {
      logic              busy;
      logic [TAG_W-1:0]  rob_idx;
      logic [OPC_W-1:0]  opcode;
      logic [IMM_W-1:0]  imm;
      logic              a_valid;
      logic [DATA_W-1:0] a_value;
      logic [TAG_W-1:0]  a_owner;
      logic              b_valid;
      logic [DATA_W-1:0] b_value;
      logic [TAG_W-1:0]  b_owner;
   } rs_entry_t;

   // An operand still waiting on a producer whose result is on the CDB.
   function automatic logic cdb_hit(
      input logic             op_valid,
      input logic [TAG_W-1:0] op_owner,
      input logic             bus_valid,
      input logic [TAG_W-1:0] bus_tag
   );
      return ~op_valid & bus_valid & (op_owner == bus_tag);
   endfunction

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-ready arbiter: age[i][j] set means entry i is younger
// than entry j, so i wins only when no ready entry is older.
module rs_age_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]        ready,
   input  logic [N-1:0][N-1:0] age,
   output logic [N-1:0]        grant,
   output logic                valid
);

   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = ready[i] & ~|(age[i] & ready);
      end
   end

   assign valid = |ready;

endmodule

// File: rtl/fxu_res_station.sv
// FXU reservation station: tag-matching wakeup, dispatch bypass
// and oldest-first issue via an age matrix.
module fxu_res_station #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = ooo_pkg::TAG_W,
   parameter int DATA_W      = ooo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              disp_valid,
   input  logic [TAG_W-1:0]  disp_rob_idx,
   input  logic [3:0]        disp_opcode,
   input  logic [7:0]        disp_imm,
   input  logic              disp_a_valid,
   input  logic              disp_b_valid,
   input  logic [DATA_W-1:0] disp_a_value,
   input  logic [DATA_W-1:0] disp_b_value,
   input  logic [TAG_W-1:0]  disp_a_owner,
   input  logic [TAG_W-1:0]  disp_b_owner,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_value,
   output logic              full,
   output logic [2:0]        count,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [TAG_W-1:0]  issue_rob_idx,
   output logic [3:0]        issue_opcode,
   output logic [7:0]        issue_imm,
   output logic [DATA_W-1:0] issue_a,
   output logic [DATA_W-1:0] issue_b
);
   import ooo_pkg::*;

   localparam int N     = NUM_ENTRIES;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   rs_entry_t           ent_q [N];
   rs_entry_t           ent_d [N];
   logic [N-1:0][N-1:0] age_q, age_d;
   logic [2:0]          count_q, count_d;
   logic                full_q, full_d;

   logic [N-1:0]        busy_vec;
   logic [N-1:0]        ready_vec;
   logic [N-1:0]        grant;
   logic                pick_valid;
   logic                iss_fire;
   logic                disp_acc;
   logic [IDX_W-1:0]    free_idx;
   logic [N-1:0]        freed;
   rs_entry_t           new_e;

   always_comb begin
      busy_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < N; i++) begin
         busy_vec[i]  = ent_q[i].busy;
         ready_vec[i] = ent_q[i].busy & ent_q[i].a_valid
                        & ent_q[i].b_valid;
      end
   end

   rs_age_picker #(.N(N)) u_picker (
      .ready (ready_vec),
      .age   (age_q),
      .grant (grant),
      .valid (pick_valid)
   );

   assign issue_valid = pick_valid & ~rst;
   assign iss_fire    = issue_valid & issue_ready;
   assign disp_acc    = disp_valid & ~full_q & ~flush & ~rst;
   assign freed       = grant & {N{iss_fire}};

   always_comb begin
      issue_rob_idx = '0;
      issue_opcode  = '0;
      issue_imm     = '0;
      issue_a       = '0;
      issue_b       = '0;
      for (int i = 0; i < N; i++) begin
         if (issue_valid && grant[i]) begin
            issue_rob_idx = issue_rob_idx | ent_q[i].rob_idx;
            issue_opcode  = issue_opcode | ent_q[i].opcode;
            issue_imm     = issue_imm | ent_q[i].imm;
            issue_a       = issue_a | ent_q[i].a_value;
            issue_b       = issue_b | ent_q[i].b_value;
         end
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!busy_vec[i]) free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      new_e         = '0;
      new_e.busy    = 1'b1;
      new_e.rob_idx = disp_rob_idx;
      new_e.opcode  = disp_opcode;
      new_e.imm     = disp_imm;
      new_e.a_owner = disp_a_owner;
      new_e.b_owner = disp_b_owner;
      new_e.a_valid = disp_a_valid;
      new_e.a_value = disp_a_value;
      new_e.b_valid = disp_b_valid;
      new_e.b_value = disp_b_value;
      if (cdb_hit(disp_a_valid, disp_a_owner, cdb_valid, cdb_tag)) begin
         new_e.a_valid = 1'b1;
         new_e.a_value = cdb_value;
      end
      if (cdb_hit(disp_b_valid, disp_b_owner, cdb_valid, cdb_tag)) begin
         new_e.b_valid = 1'b1;
         new_e.b_value = cdb_value;
      end
   end

   always_comb begin
      age_d = age_q;
      for (int i = 0; i < N; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].busy) begin
            if (cdb_hit(ent_q[i].a_valid, ent_q[i].a_owner,
                        cdb_valid, cdb_tag)) begin
               ent_d[i].a_valid = 1'b1;
               ent_d[i].a_value = cdb_value;
            end
            if (cdb_hit(ent_q[i].b_valid, ent_q[i].b_owner,
                        cdb_valid, cdb_tag)) begin
               ent_d[i].b_valid = 1'b1;
               ent_d[i].b_value = cdb_value;
            end
         end
         if (freed[i]) begin
            ent_d[i].busy = 1'b0;
            for (int r = 0; r < N; r++) age_d[r][i] = 1'b0;
         end
      end
      // Allocation row excludes the entry leaving this same edge.
      if (disp_acc) begin
         ent_d[free_idx] = new_e;
         age_d[free_idx] = busy_vec & ~freed;
      end
      count_d = count_q + 3'(disp_acc) - 3'(iss_fire);
      if (flush) begin
         for (int i = 0; i < N; i++) ent_d[i].busy = 1'b0;
         age_d   = '0;
         count_d = '0;
      end
      full_d = (count_d == 3'(N));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) ent_q[i] <= '0;
         age_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
         age_q   <= age_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign full  = full_q;
   assign count = count_q;

endmodule

// File: tb/tb_fxu_res_station.sv
// Directed bench for fxu_res_station: dispatch, wakeup, bypass,
// full/drop, age order, flush and mid-run reset.
module tb_fxu_res_station;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        disp_valid;
   logic [3:0]  disp_rob_idx;
   logic [3:0]  disp_opcode;
   logic [7:0]  disp_imm;
   logic        disp_a_valid, disp_b_valid;
   logic [15:0] disp_a_value, disp_b_value;
   logic [3:0]  disp_a_owner, disp_b_owner;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [15:0] cdb_value;
   logic        full;
   logic [2:0]  count;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_rob_idx;
   logic [3:0]  issue_opcode;
   logic [7:0]  issue_imm;
   logic [15:0] issue_a, issue_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fxu_res_station dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_rob_idx  (disp_rob_idx),
      .disp_opcode   (disp_opcode),
      .disp_imm      (disp_imm),
      .disp_a_valid  (disp_a_valid),
      .disp_b_valid  (disp_b_valid),
      .disp_a_value  (disp_a_value),
      .disp_b_value  (disp_b_value),
      .disp_a_owner  (disp_a_owner),
      .disp_b_owner  (disp_b_owner),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_value     (cdb_value),
      .full          (full),
      .count         (count),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_rob_idx (issue_rob_idx),
      .issue_opcode  (issue_opcode),
      .issue_imm     (issue_imm),
      .issue_a       (issue_a),
      .issue_b       (issue_b)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [3:0] rob, input logic [3:0] op,
                       input logic [7:0] imm,
                       input logic av, input logic [15:0] a,
                       input logic [3:0] ao,
                       input logic bv, input logic [15:0] b,
                       input logic [3:0] bo);
      disp_valid   = 1'b1;
      disp_rob_idx = rob;
      disp_opcode  = op;
      disp_imm     = imm;
      disp_a_valid = av;
      disp_a_value = a;
      disp_a_owner = ao;
      disp_b_valid = bv;
      disp_b_value = b;
      disp_b_owner = bo;
   endtask

   task automatic rdy(input logic [3:0] rob);
      disp(rob, 4'd1, 8'd0, 1'b1, 16'd1, 4'd0, 1'b1, 16'd2, 4'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
      disp_rob_idx = '0; disp_opcode = '0; disp_imm = '0;
      disp_a_valid = 1'b0; disp_b_valid = 1'b0;
      disp_a_value = '0; disp_b_value = '0;
      disp_a_owner = '0; disp_b_owner = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
      issue_ready = 1'b0;
      tick(); tick();
      check("rst_count", 32'(count), 0);
      check("rst_full", 32'(full), 0);
      check("rst_ivalid", 32'(issue_valid), 0);
      check("rst_irob", 32'(issue_rob_idx), 0);
      check("rst_ia", 32'(issue_a), 0);
      rst = 1'b0;

      // basic dispatch and issue
      disp(4'd3, 4'd0, 8'd0, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
      check("lat_pre", 32'(issue_valid), 0);
      tick();
      disp_valid = 1'b0;
      check("b_ivalid", 32'(issue_valid), 1);
      check("b_rob", 32'(issue_rob_idx), 3);
      check("b_a", 32'(issue_a), 5);
      check("b_b", 32'(issue_b), 7);
      check("b_cnt1", 32'(count), 1);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("b_cnt0", 32'(count), 0);
      check("b_idle", 32'(issue_valid), 0);

      // wakeup from CDB
      disp(4'd2, 4'd0, 8'd0, 1'b0, 16'd0, 4'd9, 1'b1, 16'd1, 4'd0);
      tick();
      disp_valid = 1'b0;
      check("w_wait1", 32'(issue_valid), 0);
      tick();
      check("w_wait2", 32'(issue_valid), 0);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 16'h00AA;
      check("w_bcast", 32'(issue_valid), 0);
      tick();
      cdb_valid = 1'b0;
      check("w_ivalid", 32'(issue_valid), 1);
      check("w_a", 32'(issue_a), 32'h00AA);
      check("w_rob", 32'(issue_rob_idx), 2);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // dispatch-cycle bypass
      disp(4'd5, 4'd3, 8'h5A, 1'b0, 16'd0, 4'd4, 1'b1, 16'd2, 4'd0);
      cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_value = 16'h1234;
      tick();
      disp_valid = 1'b0; cdb_valid = 1'b0;
      check("y_ivalid", 32'(issue_valid), 1);
      check("y_a", 32'(issue_a), 32'h1234);
      check("y_op", 32'(issue_opcode), 3);
      check("y_imm", 32'(issue_imm), 32'h5A);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // unmatched tag, then one tag waking both operands
      disp(4'd8, 4'd0, 8'd0, 1'b0, 16'd0, 4'd6, 1'b0, 16'd0, 4'd6);
      tick();
      disp_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 16'h0BAD;
      tick();
      check("m_nomatch", 32'(issue_valid), 0);
      cdb_tag = 4'd6; cdb_value = 16'h0042;
      tick();
      cdb_valid = 1'b0;
      check("m_ivalid", 32'(issue_valid), 1);
      check("m_a", 32'(issue_a), 32'h42);
      check("m_b", 32'(issue_b), 32'h42);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // fill, drop while full, then issue in age order
      rdy(4'd1); tick();
      rdy(4'd2); tick();
      rdy(4'd3); tick();
      rdy(4'd4); tick();
      check("f_full", 32'(full), 1);
      check("f_cnt", 32'(count), 4);
      check("f_rob1", 32'(issue_rob_idx), 1);
      rdy(4'd5); tick();
      check("f_drop_cnt", 32'(count), 4);
      check("f_hold", 32'(issue_rob_idx), 1);
      rdy(4'd6);
      issue_ready = 1'b1;
      tick();
      disp_valid = 1'b0;
      check("f_cnt3", 32'(count), 3);
      check("f_nfull", 32'(full), 0);
      check("f_rob2", 32'(issue_rob_idx), 2);
      tick();
      check("f_rob3", 32'(issue_rob_idx), 3);
      tick();
      check("f_rob4", 32'(issue_rob_idx), 4);
      tick();
      check("f_empty", 32'(issue_valid), 0);
      check("f_cnt0", 32'(count), 0);
      issue_ready = 1'b0;

      // reused low slot is still the younger entry
      rdy(4'd1); tick();
      rdy(4'd2); tick();
      disp_valid = 1'b0;
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      rdy(4'd7); tick();
      disp_valid = 1'b0;
      check("a_cnt", 32'(count), 2);
      check("a_old", 32'(issue_rob_idx), 2);
      issue_ready = 1'b1;
      tick();
      check("a_young", 32'(issue_rob_idx), 7);
      tick();
      issue_ready = 1'b0;
      check("a_cnt0", 32'(count), 0);

      // simultaneous issue and dispatch
      rdy(4'd10); tick();
      rdy(4'd11);
      issue_ready = 1'b1;
      tick();
      disp_valid = 1'b0;
      issue_ready = 1'b0;
      check("s_cnt", 32'(count), 1);
      check("s_rob", 32'(issue_rob_idx), 11);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // flush beats a same-cycle dispatch
      rdy(4'd1); tick();
      rdy(4'd2); tick();
      rdy(4'd3); tick();
      check("x_cnt3", 32'(count), 3);
      rdy(4'd9);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      disp_valid = 1'b0;
      check("x_cnt", 32'(count), 0);
      check("x_full", 32'(full), 0);
      check("x_ivalid", 32'(issue_valid), 0);
      tick();
      check("x_nostore", 32'(issue_valid), 0);

      // reset mid-operation
      rdy(4'd12); tick();
      rdy(4'd13); tick();
      disp_valid = 1'b0;
      rst = 1'b1;
      issue_ready = 1'b1;
      #1;
      check("r_gate", 32'(issue_valid), 0);
      check("r_gate_a", 32'(issue_a), 0);
      tick();
      rst = 1'b0;
      issue_ready = 1'b0;
      check("r_cnt", 32'(count), 0);
      check("r_ivalid", 32'(issue_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
